// File: rtl/scc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scc_pkg
// Description : Shared types and constants for the SCC buffer and its
//               interrupt status logic.
// Revision    : 1.0 - initial release
// ============================================================================
package scc_pkg;

    // Number of interrupt sources in one buffer status word
    localparam int SCC_IRQ_NUM = 6;

    // Bit position of each interrupt source inside the status word
    typedef enum logic [2:0] {
        IRQ_EMPTY     = 3'd0,
        IRQ_BELOW_LO  = 3'd1,
        IRQ_ABOVE_HI  = 3'd2,
        IRQ_FULL      = 3'd3,
        IRQ_WR_STALL  = 3'd4,
        IRQ_RD_STARVE = 3'd5
    } scc_irq_idx_e;

    // Status word layout, MSB first, matching scc_irq_idx_e
    typedef struct packed {
        logic rd_starve;
        logic wr_stall;
        logic full;
        logic above_hi;
        logic below_lo;
        logic empty;
    } scc_buf_status_t;

endpackage : scc_pkg
`default_nettype wire

// File: rtl/scc_irq_status.sv
`default_nettype none
// ============================================================================
// Module      : scc_irq_status
// Description : N sticky write-one-to-clear status bits with a per-bit mask
//               and a single combined interrupt output. Set beats clear.
// Revision    : 1.0 - initial release
// ============================================================================
module scc_irq_status
    import scc_pkg::*;
#(
    parameter int N = SCC_IRQ_NUM
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] set_i,
    input  logic [N-1:0] clr_i,
    input  logic [N-1:0] mask_i,
    output logic [N-1:0] status_o,
    output logic         irq_o
);

    logic [N-1:0] r_status;

    // Sticky bits: clear requested bits first, then OR in new events so a
    // simultaneous set is never lost
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~clr_i) | set_i;
        end
    end

    assign status_o = r_status;
    assign irq_o    = |(r_status & mask_i);

endmodule : scc_irq_status
`default_nettype wire

// File: rtl/scc_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : scc_buf_fifo
// Description : First-word fall-through data buffer with programmable low /
//               high watermarks, flush, sticky interrupt status and pointer
//               monitors. One instance per buffer direction.
// Revision    : 1.0 - initial release
// ============================================================================
module scc_buf_fifo
    import scc_pkg::*;
#(
    parameter  int DATA_WIDTH = 128,
    parameter  int DEPTH      = 512,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_WIDTH-1:0]  in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  out_data_o,
    input  logic                   flush_i,
    input  logic [CW-1:0]          cfg_lo_thr_i,
    input  logic [CW-1:0]          cfg_hi_thr_i,
    input  logic [SCC_IRQ_NUM-1:0] irq_mask_i,
    input  logic [SCC_IRQ_NUM-1:0] irq_clr_i,
    output logic [SCC_IRQ_NUM-1:0] irq_status_o,
    output logic                   irq_o,
    output logic [CW-1:0]          level_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [CW-1:0]          mon_wptr_o,
    output logic [CW-1:0]          mon_rptr_o
);

    localparam logic [CW-1:0] c_full_level = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_wptr;
    logic [CW-1:0]         r_rptr;
    logic [CW-1:0]         r_level;
    logic [CW-1:0]         w_level_d;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    scc_buf_status_t       w_set;

    // Same index with opposite wrap bits means the write side lapped the read side
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_empty = (r_wptr == r_rptr);

    // Flush swallows any transfer offered in the same cycle
    assign w_push = in_valid_i  & ~w_full  & ~flush_i;
    assign w_pop  = out_ready_i & ~w_empty & ~flush_i;

    // Next occupancy, used both for the level register and for edge events
    always_comb begin
        w_level_d = r_level;
        if (flush_i) begin
            w_level_d = '0;
        end else begin
            w_level_d = r_level + CW'(w_push) - CW'(w_pop);
        end
    end

    // Level-crossing events are taken on the transition, so threshold
    // reprogramming alone cannot fire them
    always_comb begin
        w_set           = '0;
        w_set.empty     = (r_level != '0) && (w_level_d == '0);
        w_set.full      = (r_level != c_full_level) && (w_level_d == c_full_level);
        w_set.below_lo  = (r_level >= cfg_lo_thr_i) && (w_level_d < cfg_lo_thr_i);
        w_set.above_hi  = (r_level <= cfg_hi_thr_i) && (w_level_d > cfg_hi_thr_i);
        w_set.wr_stall  = in_valid_i & w_full & ~flush_i;
        w_set.rd_starve = out_ready_i & w_empty;
    end

    // Pointer and occupancy state
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level <= w_level_d;
        end
    end

    // Storage array; contents are intentionally left unreset
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= in_data_i;
        end
    end

    scc_irq_status #(
        .N (SCC_IRQ_NUM)
    ) u_irq_status (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .set_i    (w_set),
        .clr_i    (irq_clr_i),
        .mask_i   (irq_mask_i),
        .status_o (irq_status_o),
        .irq_o    (irq_o)
    );

    assign out_data_o  = r_mem[r_rptr[AW-1:0]];
    assign in_ready_o  = ~w_full;
    assign out_valid_o = ~w_empty;
    assign empty_o     = w_empty;
    assign full_o      = w_full;
    assign level_o     = r_level;
    assign mon_wptr_o  = r_wptr;
    assign mon_rptr_o  = r_rptr;

endmodule : scc_buf_fifo
`default_nettype wire

// File: tb/tb_scc_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_scc_buf_fifo
// Description : Randomised self-checking bench for scc_buf_fifo with a
//               queue-based reference model and a decoupled data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scc_buf_fifo;

    localparam int DW  = 32;
    localparam int DEP = 8;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          flush = 1'b0;
    logic [CW-1:0] lo_thr = 4'd2;
    logic [CW-1:0] hi_thr = 4'd6;
    logic [5:0]    irq_mask = 6'h3F;
    logic [5:0]    irq_clr = '0;
    logic [5:0]    irq_status;
    logic          irq;
    logic [CW-1:0] level;
    logic          empty;
    logic          full;
    logic [CW-1:0] mon_wptr;
    logic [CW-1:0] mon_rptr;

    int checks   = 0;
    int failures = 0;

    // Reference model state: occupancy, total push/pop counts, status word
    int         m_level  = 0;
    int         m_pushes = 0;
    int         m_pops   = 0;
    logic [5:0] m_status = '0;
    logic [DW-1:0] exp_q[$];

    scc_buf_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .flush_i(flush), .cfg_lo_thr_i(lo_thr), .cfg_hi_thr_i(hi_thr),
        .irq_mask_i(irq_mask), .irq_clr_i(irq_clr),
        .irq_status_o(irq_status), .irq_o(irq),
        .level_o(level), .empty_o(empty), .full_o(full),
        .mon_wptr_o(mon_wptr), .mon_rptr_o(mon_rptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: compare present outputs, then advance by the inputs
    // that will be sampled at the coming rising edge
    always @(negedge clk) begin
        int nl;
        bit push, pop, m_full, m_empty;
        logic [5:0] set;
        if (!rst) begin
            chk("level", 64'(level), 64'(m_level));
            chk("empty", 64'(empty), 64'(m_level == 0));
            chk("full", 64'(full), 64'(m_level == DEP));
            chk("in_ready", 64'(in_ready), 64'(m_level != DEP));
            chk("out_valid", 64'(out_valid), 64'(m_level != 0));
            chk("status", 64'(irq_status), 64'(m_status));
            chk("irq", 64'(irq), 64'(|(m_status & irq_mask)));
            chk("wptr", 64'(mon_wptr), 64'(m_pushes % (2 * DEP)));
            chk("rptr", 64'(mon_rptr), 64'(m_pops % (2 * DEP)));
        end
        if (rst) begin
            m_level = 0; m_pushes = 0; m_pops = 0; m_status = '0;
            exp_q.delete();
        end else begin
            m_full  = (m_level == DEP);
            m_empty = (m_level == 0);
            push = !flush && in_valid && !m_full;
            pop  = !flush && out_ready && !m_empty;
            nl   = flush ? 0 : m_level + int'(push) - int'(pop);
            set = '0;
            set[0] = (m_level != 0) && (nl == 0);
            set[1] = (m_level >= int'(lo_thr)) && (nl < int'(lo_thr));
            set[2] = (m_level <= int'(hi_thr)) && (nl > int'(hi_thr));
            set[3] = (m_level != DEP) && (nl == DEP);
            set[4] = in_valid && m_full && !flush;
            set[5] = out_ready && m_empty;
            m_status = (m_status & ~irq_clr) | set;
            if (flush) begin
                m_pushes = 0; m_pops = 0;
                exp_q.delete();
            end else begin
                if (push) begin
                    m_pushes++;
                    exp_q.push_back(in_data);
                end
                if (pop) m_pops++;
            end
            m_level = nl;
        end
    end

    // Monitor: whenever the DUT hands over a word, it must be the oldest accepted one
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 64'(out_data), 64'hDEAD_0000);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e));
            end
        end
    end

    // One cycle of stimulus, launched just after a rising edge
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r,
                       input bit f, input logic [5:0] c);
        in_valid = v; in_data = d; out_ready = r; flush = f; irq_clr = c;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; irq_clr = '0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // Reset values against constants
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_status", 64'(irq_status), 64'd0);

        // Fill to full with A0..A7, then one push against full
        for (int i = 0; i < 8; i++) cyc(1, 32'hA0 + i, 0, 0, 0);
        chk("fill_level", 64'(level), 64'd8);
        chk("fill_ready", 64'(in_ready), 64'd0);
        chk("fill_flags", 64'(irq_status & 6'h0C), 64'h0C);
        // Push+pop at full: only the pop lands
        cyc(1, 32'hBB, 1, 0, 0);
        chk("full_pp_level", 64'(level), 64'd7);
        chk("wr_stall", 64'(irq_status[4]), 64'd1);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0);
        chk("drain_flags", 64'(irq_status & 6'h03), 64'h03);
        chk("drain_irq", 64'(irq), 64'd1);

        // Level 3, push+pop keeps level
        cyc(0, 0, 0, 0, 6'h3F);
        for (int i = 0; i < 3; i++) cyc(1, 32'hC0 + i, 0, 0, 0);
        cyc(1, 32'hC3, 1, 0, 0);
        chk("pp3_level", 64'(level), 64'd3);

        // Wrap: hold level 4 through 20 push+pop cycles
        cyc(1, 32'hC4, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 32'hD0 + i, 1, 0, 0);
        chk("wrap_level", 64'(level), 64'd4);

        // Flush at level 5 with simultaneous push
        cyc(1, 32'hE0, 0, 0, 6'h3F);
        cyc(1, 32'hE1, 0, 1, 0);
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_flags", 64'(irq_status & 6'h03), 64'h03);

        // Clear colliding with a new EMPTY event: set wins; then clear alone
        irq_mask = 6'h01;
        cyc(0, 0, 0, 0, 6'h3F);
        cyc(1, 32'hF0, 0, 0, 0);
        cyc(0, 0, 1, 0, 6'h01);
        chk("clr_vs_set", 64'(irq_status[0]), 64'd1);
        cyc(0, 0, 0, 0, 6'h01);
        chk("clr_alone", 64'(irq_status[0]), 64'd0);
        chk("clr_irq", 64'(irq), 64'd0);
        irq_mask = 6'h3F;

        // Reset mid-burst at level 5
        for (int i = 0; i < 5; i++) cyc(1, 32'h50 + i, 0, 0, 0);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_status", 64'(irq_status), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);

        // Random traffic with occasional threshold, mask, clear and flush activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                lo_thr = 4'($urandom_range(0, 9));
                hi_thr = 4'($urandom_range(0, 15));
                irq_mask = 6'($urandom);
            end
            cyc(($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 99) < 2), ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'h0);
        end
        // Drain and confirm scoreboard empties
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0);
        @(negedge clk); #1;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_scc_buf_fifo
`default_nettype wire
